// File: rtl/seg_serial_shifter_if.sv
// Parallel-side handshake bundle for seg_serial_shifter.
//   data  : 64-bit segment pattern, bit 63 shifted out first
//   start : transfer request, taken only while ready is high
//   ready : shifter idle and able to accept start
//   done  : one-cycle pulse at the start of the latch phase
// master drives data/start, slave (the shifter) drives ready/done.
interface seg_serial_shifter_if;
  logic [63:0] data;
  logic        start;
  logic        ready;
  logic        done;

  modport master (output data, output start, input ready, input done);
  modport slave  (input data, input start, output ready, output done);
endinterface

// File: rtl/seg_serial_shifter.sv
// Serialises a 64-bit segment pattern into an external shift/latch register.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   bus         : seg_serial_shifter_if.slave (data, start, ready, done)
//   seg_clk     : serial shift clock, external register samples on its rise
//   seg_do      : serial data bit (optionally inverted by INVERT)
//   seg_pen     : parallel enable, low while shifting, rising edge latches
//   seg_clr_n   : external register clear, active-low, held low in reset
// Parameters: CLK_DIV (seg_clk half-period, 1..255), INVERT, REFRESH_CYCLES.
// Optional feature: define SEG_AUTO_REFRESH_EN to compile in a periodic
// self-start that resends the current data every REFRESH_CYCLES idle cycles.
module seg_serial_shifter #(
  parameter int unsigned CLK_DIV        = 2,
  parameter bit          INVERT         = 1'b0,
  parameter int unsigned REFRESH_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg_serial_shifter_if.slave  bus,
  output logic                 seg_clk,
  output logic                 seg_do,
  output logic                 seg_pen,
  output logic                 seg_clr_n
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } state_t;

  // every state entry reloads the divider with this value
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 32'd1);

  state_t      state_r, state_s;
  logic [63:0] shreg_r, shreg_s;
  logic [5:0]  idx_r, idx_s;
  logic [7:0]  div_r, div_s;
  logic        ready_r, ready_s;
  logic        done_r, done_s;
  logic        seg_clk_r, seg_clk_s;
  logic        seg_do_r, seg_do_s;
  logic        seg_pen_r, seg_pen_s;
  logic        seg_clr_n_r;
  logic        launch_s;

`ifdef SEG_AUTO_REFRESH_EN
  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 32'd1);

  logic [31:0] refresh_cnt_r;
  logic        self_start_s;

  assign self_start_s = (state_r == ST_IDLE) && (refresh_cnt_r == REFRESH_LAST);
  // an external start coinciding with a self-start is one and the same launch
  assign launch_s     = ready_r && (bus.start || self_start_s);

  // refresh interval counter: cleared by the latch phase, counts idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_r <= 32'd0;
    end else if (state_r == ST_LATCH) begin
      refresh_cnt_r <= 32'd0;
    end else if (state_r == ST_IDLE) begin
      refresh_cnt_r <= refresh_cnt_r + 32'd1;
    end else begin
      refresh_cnt_r <= refresh_cnt_r;
    end
  end
`else
  // ready_r is only ever high in IDLE, so it doubles as the accept qualifier
  assign launch_s = ready_r && bus.start;

  // REFRESH_CYCLES has no role without auto-refresh
  if (REFRESH_CYCLES == 32'd0) begin : g_refresh_unused
  end
`endif

  // next-state, shift register, bit index and divider update
  always_comb begin
    state_s = state_r;
    shreg_s = shreg_r;
    idx_s   = idx_r;
    div_s   = div_r;
    case (state_r)
      ST_IDLE: begin
        if (launch_s) begin
          state_s = ST_SHIFT_LO;
          shreg_s = bus.data;
          idx_s   = 6'd63;
          div_s   = DIV_RELOAD;
        end else begin
          div_s   = div_r;
        end
      end
      ST_SHIFT_LO: begin
        if (div_r == 8'd0) begin
          state_s = ST_SHIFT_HI;
          div_s   = DIV_RELOAD;
        end else begin
          div_s   = div_r - 8'd1;
        end
      end
      ST_SHIFT_HI: begin
        if (div_r == 8'd0) begin
          shreg_s = {shreg_r[62:0], 1'b0};
          idx_s   = idx_r - 6'd1;
          div_s   = DIV_RELOAD;
          state_s = (idx_r != 6'd0) ? ST_SHIFT_LO : ST_LATCH;
        end else begin
          div_s   = div_r - 8'd1;
        end
      end
      ST_LATCH: begin
        state_s = ST_IDLE;
        div_s   = DIV_RELOAD;
      end
      default: begin
        state_s = ST_IDLE;
        div_s   = DIV_RELOAD;
      end
    endcase
  end

  // output decode from the next state so every output leaves a flop
  always_comb begin
    ready_s   = (state_s == ST_IDLE);
    done_s    = (state_s == ST_LATCH);
    seg_clk_s = (state_s == ST_SHIFT_HI);
    seg_pen_s = (state_s == ST_IDLE) || (state_s == ST_LATCH);
    // seg_do only moves when a low phase begins; it holds through HI/LATCH/IDLE
    if (state_s == ST_SHIFT_LO) begin
      seg_do_s = shreg_s[63] ^ INVERT;
    end else begin
      seg_do_s = seg_do_r;
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shreg_r     <= 64'd0;
      idx_r       <= 6'd0;
      div_r       <= 8'd0;
      ready_r     <= 1'b0;
      done_r      <= 1'b0;
      seg_clk_r   <= 1'b0;
      seg_do_r    <= 1'b0;
      seg_pen_r   <= 1'b1;
      seg_clr_n_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      idx_r       <= idx_s;
      div_r       <= div_s;
      ready_r     <= ready_s;
      done_r      <= done_s;
      seg_clk_r   <= seg_clk_s;
      seg_do_r    <= seg_do_s;
      seg_pen_r   <= seg_pen_s;
      seg_clr_n_r <= 1'b1;
    end
  end

  assign bus.ready = ready_r;
  assign bus.done  = done_r;
  assign seg_clk   = seg_clk_r;
  assign seg_do    = seg_do_r;
  assign seg_pen   = seg_pen_r;
  assign seg_clr_n = seg_clr_n_r;

endmodule

// File: tb/tb_seg_serial_shifter.sv
// Bench for seg_serial_shifter: two instances (INVERT=0 and INVERT=1) share
// one stimulus; a transfer-level model predicts every output each cycle.
module tb_seg_serial_shifter;
  localparam int unsigned D    = 2;
  localparam int unsigned TLEN = 128 * D;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] data  = 64'd0;
  logic        start = 1'b0;
  int unsigned edge_cnt = 0;
  int unsigned base     = 0;
  int          checks   = 0;
  int          passes   = 0;

  always #5 clk = ~clk;

  seg_serial_shifter_if bus0 ();
  seg_serial_shifter_if bus1 ();
  assign bus0.data  = data;
  assign bus0.start = start;
  assign bus1.data  = data;
  assign bus1.start = start;

  logic sclk0, sdo0, spen0, sclr0, sclk1, sdo1, spen1, sclr1;

  seg_serial_shifter #(.CLK_DIV(D), .INVERT(1'b0), .REFRESH_CYCLES(1000000)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave),
    .seg_clk(sclk0), .seg_do(sdo0), .seg_pen(spen0), .seg_clr_n(sclr0));

  seg_serial_shifter #(.CLK_DIV(D), .INVERT(1'b1), .REFRESH_CYCLES(1000000)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave),
    .seg_clk(sclk1), .seg_do(sdo1), .seg_pen(spen1), .seg_clr_n(sclr1));

  logic [1:0] v_rdy, v_done, v_clk, v_do, v_pen, v_clr;
  assign v_rdy  = {bus1.ready, bus0.ready};
  assign v_done = {bus1.done, bus0.done};
  assign v_clk  = {sclk1, sclk0};
  assign v_do   = {sdo1, sdo0};
  assign v_pen  = {spen1, spen0};
  assign v_clr  = {sclr1, sclr0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %b required %b", name, act, exp);
  endtask

  // cycles since reset release (cycle boundary = rising clk edge)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // advance to #1 after the rising edge that starts cycle n relative to base
  task automatic go_cycle(input int unsigned n);
    while (edge_cnt < base + n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- transfer-level model and per-cycle compare ----------------
  bit          m_busy = 1'b0;
  int unsigned m_acc  = 0;
  logic [63:0] m_pat  = 64'd0;
  logic [1:0]  m_do   = 2'b00;
  logic [1:0]  m_prev = 2'b00;
  logic [63:0] m_cap [2];
  int          m_ncap [2];
  logic        e_ready, e_done, e_clk, e_pen, e_clr;
  int unsigned off, k;

  initial begin : compare
    m_cap[0] = 64'd0; m_cap[1] = 64'd0; m_ncap[0] = 0; m_ncap[1] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 1'b0; m_do = 2'b00; m_prev = 2'b00;
        m_ncap[0] = 0; m_ncap[1] = 0;
        e_ready = 1'b0; e_done = 1'b0; e_clk = 1'b0; e_pen = 1'b1; e_clr = 1'b0;
      end else begin
        e_ready = 1'b0; e_done = 1'b0; e_clk = 1'b0; e_pen = 1'b1;
        e_clr   = (edge_cnt > 0);
        if (m_busy) begin
          off = edge_cnt - m_acc + 1;
          if (off <= TLEN) begin
            k     = (off - 1) / (2 * D);
            e_clk = ((off - 1) % (2 * D)) >= D;
            e_pen = 1'b0;
            m_do  = {2{m_pat[63 - k]}} ^ 2'b10;
          end else if (off == TLEN + 1) begin
            e_done = 1'b1;
          end else begin
            m_busy = 1'b0;
          end
        end
        if (!m_busy) e_ready = (edge_cnt > 0);
      end
      for (int i = 0; i < 2; i++) begin
        chk1($sformatf("ready%0d", i),   v_rdy[i],  e_ready);
        chk1($sformatf("done%0d", i),    v_done[i], e_done);
        chk1($sformatf("seg_clk%0d", i), v_clk[i],  e_clk);
        chk1($sformatf("seg_pen%0d", i), v_pen[i],  e_pen);
        chk1($sformatf("seg_clr%0d", i), v_clr[i],  e_clr);
        chk1($sformatf("seg_do%0d", i),  v_do[i],   m_do[i]);
        if (rst_n) begin
          if (v_clk[i] && !m_prev[i]) begin
            m_cap[i]  = {m_cap[i][62:0], v_do[i]};
            m_ncap[i] = m_ncap[i] + 1;
          end
          m_prev[i] = v_clk[i];
          if (e_done) begin
            chk($sformatf("rises%0d", i), 64'(m_ncap[i]), 64'd64);
            chk($sformatf("pattern%0d", i), m_cap[i], (i == 1) ? ~m_pat : m_pat);
            m_ncap[i] = 0;
          end
        end
      end
      if (rst_n && e_ready && start) begin
        m_busy = 1'b1;
        m_acc  = edge_cnt + 1;
        m_pat  = data;
      end
    end
  end

`ifdef SEG_AUTO_REFRESH_EN
  seg_serial_shifter_if bus2 ();
  assign bus2.data  = 64'hF0F0_0F0F_AAAA_5555;
  assign bus2.start = 1'b0;
  logic sclk2, sdo2, spen2, sclr2;
  int   r_done_at = -1;
  int   r_rises   = 0;
  logic r_prev_clk = 1'b0;
  logic r_prev_pen = 1'b1;

  seg_serial_shifter #(.CLK_DIV(1), .INVERT(1'b0), .REFRESH_CYCLES(50)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave),
    .seg_clk(sclk2), .seg_do(sdo2), .seg_pen(spen2), .seg_clr_n(sclr2));

  initial begin : refresh_mon
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_done_at = -1; r_rises = 0; r_prev_clk = 1'b0; r_prev_pen = 1'b1;
      end else begin
        if (sclk2 && !r_prev_clk) r_rises++;
        if (!spen2 && r_prev_pen) begin
          // accept 50 cycles after done, seg_pen falls the cycle after accept
          if (r_done_at >= 0) chk("refresh_gap", 64'(int'(edge_cnt) - r_done_at), 64'd51);
          r_rises = 0;
        end
        if (bus2.done) begin
          chk("refresh_rises", 64'(r_rises), 64'd64);
          r_done_at = int'(edge_cnt);
        end
        r_prev_clk = sclk2;
        r_prev_pen = spen2;
      end
    end
  end
`endif

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_clr_n", sclr0, 1'b0);
    chk1("rst_ready", bus0.ready, 1'b0);
    chk1("rst_pen", spen0, 1'b1);
    chk1("rst_clk", sclk0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("rel_clr_n", sclr0, 1'b1);
    chk1("rel_ready", bus0.ready, 1'b1);

    // single transfer, start pulse and data change mid-transfer are ignored
    base  = edge_cnt;
    data  = 64'h8000_0000_0000_0001;
    start = 1'b1;
    go_cycle(1);   start = 1'b0;
    go_cycle(2);   chk1("t1_clk_c2", sclk0, 1'b0);
    go_cycle(3);   chk1("t1_clk_c3", sclk0, 1'b1);
                   chk1("t1_do_c3", sdo0, 1'b1);
                   chk1("t1_doinv_c3", sdo1, 1'b0);
    go_cycle(7);   chk1("t1_do_c7", sdo0, 1'b0);
    go_cycle(10);  start = 1'b1;
    go_cycle(11);  start = 1'b0;
    go_cycle(20);  data = 64'h1234_5678_9ABC_DEF0;
    go_cycle(255); chk1("t1_clk_c255", sclk0, 1'b1);
                   chk1("t1_do_c255", sdo0, 1'b1);
    go_cycle(256); chk1("t1_done_c256", bus0.done, 1'b0);
    go_cycle(257); chk1("t1_done_c257", bus0.done, 1'b1);
                   chk1("t1_ready_c257", bus0.ready, 1'b0);
    go_cycle(258); chk1("t1_ready_c258", bus0.ready, 1'b1);
                   chk1("t1_done_c258", bus0.done, 1'b0);

    // back-to-back transfers with start held high
    base  = edge_cnt;
    data  = 64'hDEAD_BEEF_0123_4567;
    start = 1'b1;
    go_cycle(1);   data = 64'h0F1E_2D3C_4B5A_6978;
    go_cycle(258); chk1("b2b_ready_c258", bus0.ready, 1'b1);
    go_cycle(259); start = 1'b0;
                   chk1("b2b_pen_c259", spen0, 1'b0);
    go_cycle(516); chk1("b2b_ready_end", bus0.ready, 1'b1);

    // reset in the middle of a transfer
    base  = edge_cnt;
    data  = 64'hFFFF_0000_FFFF_0000;
    start = 1'b1;
    go_cycle(1);   start = 1'b0;
    go_cycle(100);
    #1 rst_n = 1'b0;
    #1;
    chk1("abort_clk", sclk0, 1'b0);
    chk1("abort_pen", spen0, 1'b1);
    chk1("abort_do", sdo0, 1'b0);
    chk1("abort_ready", bus0.ready, 1'b0);
    chk1("abort_done", bus0.done, 1'b0);
    chk1("abort_clr_n", sclr0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk1("abort_rel_ready", bus0.ready, 1'b1);

    // recovery transfer after the aborted one
    base  = edge_cnt;
    data  = 64'hA5C3_3CA5_0FF0_9669;
    start = 1'b1;
    go_cycle(1);   start = 1'b0;
    go_cycle(258); chk1("rec_ready", bus0.ready, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg_serial_shifter.md
SEG_SERIAL_SHIFTER -- requirements
Module: seg_serial_shifter

Interface
REQ-001 Parameter CLK_DIV, default 2, SHALL set the seg_clk half-period in clk cycles; legal range 1..255.
REQ-002 Parameter INVERT, default 0, SHALL invert every shifted bit when set to 1, for active-low segment drivers.
REQ-003 Parameter REFRESH_CYCLES, default 1000000, SHALL set the auto-refresh interval in clk cycles; it is used only under REQ-031.
REQ-004 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 data  input  64  parallel segment pattern; bit 63 is shifted first.
REQ-007 start  input  1  transfer request; it is accepted only in a cycle where ready=1.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 done  output  1  one-cycle pulse when the latch phase begins.
REQ-010 seg_clk  output  1  serial shift clock; the external register samples on its rising edge.
REQ-011 seg_do  output  1  serial data bit.
REQ-012 seg_pen  output  1  parallel-enable/latch; low while shifting, and its rising edge latches the pattern.
REQ-013 seg_clr_n  output  1  external register clear, active-low.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT_LO, SHIFT_HI and LATCH.
REQ-015 IDLE: ready=1, seg_clk=0, seg_pen=1; when start=1, data SHALL be captured into a 64-bit shift register and the state SHALL move to SHIFT_LO with bit index 63.
REQ-016 start=0, or start asserted while ready=0, SHALL have no effect; it is not queued.
REQ-017 SHIFT_LO: seg_clk=0, seg_pen=0, seg_do=current bit XOR INVERT; the state SHALL be held for CLK_DIV cycles and then move to SHIFT_HI.
REQ-018 SHIFT_HI: seg_clk=1; seg_do SHALL stay stable; the state SHALL be held for CLK_DIV cycles.
REQ-019 On leaving SHIFT_HI, the block SHALL shift the register left by one bit and decrement the bit index. The next state SHALL be SHIFT_LO if the index was above 0, and LATCH otherwise.
REQ-020 LATCH: seg_clk=0, seg_pen=1, done=1, lasting exactly one cycle; the next state SHALL be IDLE.
REQ-021 Latency, with start accepted at cycle 0: the first seg_clk rise SHALL occur at cycle 1+CLK_DIV; done SHALL occur at cycle 1+128*CLK_DIV; ready SHALL be high again at cycle 2+128*CLK_DIV.
REQ-022 Exactly 64 seg_clk rising edges SHALL occur per transfer, with no glitches; seg_do SHALL change only in the first cycle of SHIFT_LO.
REQ-023 Changes on data during a transfer SHALL NOT affect the bits being shifted.
REQ-024 The divider counter SHALL be 8 bits wide, reload to CLK_DIV-1 on every state entry, and count down to 0.
REQ-025 start held high continuously SHALL produce back-to-back transfers, each using the data present in its accept cycle.

Reset
REQ-026 When rst_n is low, the block SHALL asynchronously force: state IDLE, ready=0, done=0, seg_clk=0, seg_do=0, seg_pen=1, seg_clr_n=0, shift register 0, counters 0.
REQ-027 ready and seg_clr_n SHALL go to 1 on the first clk rising edge after rst_n deasserts.
REQ-028 Reset mid-transfer SHALL abort the transfer immediately; no done pulse is produced, and no further seg_clk edge occurs.

Configuration
REQ-029 The macro SEG_AUTO_REFRESH_EN SHALL select whether auto-refresh is compiled in.
REQ-030 Without SEG_AUTO_REFRESH_EN, transfers SHALL occur only on start, and no refresh counter is present.
REQ-031 With SEG_AUTO_REFRESH_EN, a 32-bit counter SHALL clear on done and increment in IDLE. When it reaches REFRESH_CYCLES-1 in IDLE, the block SHALL self-start a transfer using the current data, exactly as an accepted start.
REQ-032 With SEG_AUTO_REFRESH_EN, an external start in the same cycle as a self-start SHALL produce one transfer only.

Verification
REQ-033 Reset release with CLK_DIV=2: seg_clr_n=0 and ready=0 during reset; both are 1 one cycle after release; seg_pen=1 and seg_clk=0 throughout.
REQ-034 data=64'h8000_0000_0000_0001, INVERT=0, CLK_DIV=2, start at cycle 0: seg_do=1 sampled at the first rise (cycle 3); bits 62..1 sample 0; bit 0 samples 1 at the rise in cycle 255; done at 257; ready at 258.
REQ-035 The same stimulus with INVERT=1: the 64 sampled bits are the complement, i.e. 64'h7FFF_FFFF_FFFF_FFFE.
REQ-036 start pulsed at cycle 10 and data changed at cycle 20 during a transfer: no new transfer is started, and the shifted pattern equals the cycle-0 data.
REQ-037 rst_n driven low at cycle 100 mid-transfer: outputs take their reset values at once, and no done pulse is produced.
REQ-038 With SEG_AUTO_REFRESH_EN, REFRESH_CYCLES=50, CLK_DIV=1: after the first done, the next transfer starts automatically 50 cycles after done, and seg_clk-rise counts remain 64 per transfer.
